// File: rtl/fetch_aligner.sv
// Instruction-fetch realigner for an RV32IC core: buffers word fetches as halfwords
// and hands decode one aligned 16- or 32-bit instruction per handshake.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_compressed
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  count_reg, count_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] cur_pc_reg, cur_pc_next;
  logic        skip_lo_reg, skip_lo_next;

  logic [15:0] hb [3];
  logic [79:0] hb_flat;
  logic        hb0_is_c;
  logic        pop;
  logic        append;
  logic [1:0]  pop_n;
  logic [1:0]  append_n;
  logic [1:0]  base;
  logic [1:0]  base_p1;

  assign hb0_is_c = (hb[0][1:0] != 2'b11);

  always_comb begin
    out_valid = 1'b0;
    out_instr = 32'h0;
    if (count_reg != 2'd0 && hb0_is_c) begin
      out_valid = 1'b1;
      out_instr = {16'h0, hb[0]};
    end else if (count_reg >= 2'd2 && !hb0_is_c) begin
      out_valid = 1'b1;
      out_instr = {hb[1], hb[0]};
    end
  end

  assign out_compressed = out_valid && hb0_is_c;
  assign out_pc         = cur_pc_reg;
  // rst gates the request so nothing is issued while the core is held in reset
  assign fetch_req      = rst && (state_reg == ST_FETCH) && (count_reg <= 2'd1) && !redirect;
  assign fetch_addr     = fetch_pc_reg;

  assign pop      = out_valid && out_ready;
  assign append   = (state_reg == ST_WAIT) && mem_rvalid;
  assign pop_n    = pop ? (hb0_is_c ? 2'd1 : 2'd2) : 2'd0;
  assign append_n = append ? (skip_lo_reg ? 2'd1 : 2'd2) : 2'd0;
  assign base     = count_reg - pop_n;
  assign base_p1  = base + 2'd1;
  assign hb_flat  = {32'h0, hb[2], hb[1], hb[0]};

  // Each entry takes the shifted-down halfword, unless the incoming word lands on it.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hb
      logic [15:0] entry_reg, entry_next, shifted;

      assign hb[gi]  = entry_reg;
      assign shifted = hb_flat[7'(16 * gi) + {1'b0, pop_n, 4'b0000} +: 16];

      always_comb begin
        entry_next = shifted;
        if (append) begin
          if (base == 2'(gi))
            entry_next = skip_lo_reg ? mem_rdata[31:16] : mem_rdata[15:0];
          else if (!skip_lo_reg && base_p1 == 2'(gi))
            entry_next = mem_rdata[31:16];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) entry_reg <= 16'h0;
        else      entry_reg <= entry_next;
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    fetch_pc_next = fetch_pc_reg;
    cur_pc_next   = cur_pc_reg;
    skip_lo_next  = skip_lo_reg;
    if (redirect) begin
      count_next    = 2'd0;
      cur_pc_next   = redirect_pc & ~32'h1;
      fetch_pc_next = redirect_pc & ~32'h3;
      skip_lo_next  = redirect_pc[1];
      // a response still owed by memory must be swallowed before refetching
      if (((state_reg == ST_WAIT || state_reg == ST_DRAIN) && !mem_rvalid) ||
          (state_reg == ST_FETCH && fetch_gnt))
        state_next = ST_DRAIN;
      else
        state_next = ST_FETCH;
    end else begin
      count_next  = base + append_n;
      cur_pc_next = cur_pc_reg + {29'h0, pop_n, 1'b0};
      case (state_reg)
        ST_FETCH: if (fetch_req && fetch_gnt) begin
          state_next    = ST_WAIT;
          fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        ST_WAIT: if (mem_rvalid) begin
          state_next   = ST_FETCH;
          skip_lo_next = 1'b0;
        end
        ST_DRAIN: if (mem_rvalid) state_next = ST_FETCH;
        default: state_next = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_FETCH;
      count_reg    <= 2'd0;
      fetch_pc_reg <= RESET_PC & ~32'h3;
      cur_pc_reg   <= RESET_PC & ~32'h1;
      skip_lo_reg  <= RESET_PC[1];
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      fetch_pc_reg <= fetch_pc_next;
      cur_pc_reg   <= cur_pc_next;
      skip_lo_reg  <= skip_lo_next;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: a memory model with random grant/latency feeds the DUT and every
// delivered instruction is compared with one decoded straight from the program image.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req, fetch_gnt = 1'b0;
  logic [31:0] fetch_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid, out_ready = 1'b0, out_compressed;
  logic [31:0] out_instr, out_pc;

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_compressed(out_compressed)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] prog [256];
  bit          mem_pending = 0;
  logic [31:0] pend_addr = 32'h0;
  int          lat_cnt = 0;
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  logic [31:0] gnt_log [$];

  bit          obs_pop, obs_valid, obs_req, obs_rvalid;
  logic [31:0] obs_instr, obs_pc, obs_raddr;
  logic        obs_comp;
  logic [31:0] q_instr [$];
  logic [31:0] q_pc [$];
  logic        q_comp [$];

  // Reference decode straight from the program image (memory aliases every 1 KiB).
  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = prog[pc[9:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    logic [15:0] lo;
    lo = hw_at(pc);
    if (lo[1:0] != 2'b11) return {16'h0, lo};
    return {hw_at(pc + 32'd2), lo};
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic [31:0] ga;
    bit          g;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    obs_rvalid = 1'b0;
    if (mem_pending && lat_cnt == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = prog[pend_addr[9:2]];
      obs_rvalid = 1'b1;
      obs_raddr  = pend_addr;
    end
    #1;
    fetch_gnt = fetch_req && !mem_pending && ($urandom_range(0, 99) < gnt_pct);
    #1;
    obs_valid = out_valid;
    obs_req   = fetch_req;
    obs_pop   = out_valid && out_ready && !redirect && rst;
    obs_instr = out_instr;
    obs_pc    = out_pc;
    obs_comp  = out_compressed;
    ga = fetch_addr;
    g  = fetch_gnt;
    @(posedge clk);
    if (mem_rvalid) mem_pending = 0;
    else if (mem_pending) lat_cnt--;
    if (g) begin
      mem_pending = 1;
      pend_addr   = ga;
      lat_cnt     = $urandom_range(lat_min, lat_max);
      gnt_log.push_back(ga);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b0; mem_pending = 0;
    step();
    step();
    rst = 1'b1;
    gnt_log.delete();
    q_instr.delete(); q_pc.delete(); q_comp.delete();
  endtask

  task automatic collect(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && q_instr.size() < n; i++) begin
      step();
      if (obs_pop) begin
        q_instr.push_back(obs_instr); q_pc.push_back(obs_pc); q_comp.push_back(obs_comp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", fetch_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0 || out_compressed !== 1'b0) begin errors++; $display("FAIL reset_instr got %h/%b want 0/0", out_instr, out_compressed); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
    @(negedge clk);
    step();
    rst = 1'b1;
    #1;
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req got %b@%h want 1@0", fetch_req, fetch_addr); end
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_word32();
    logic [31:0] a1;
    prog[0] = 32'h0000_0013; prog[1] = 32'h0000_0013;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    do_reset();
    out_ready = 1'b1;
    collect(1, 20);
    for (int i = 0; i < 20 && gnt_log.size() < 2; i++) step();
    a1 = (gnt_log.size() >= 2) ? gnt_log[1] : 32'hxxxx_xxxx;
    checks++; if (q_instr.size() < 1) begin errors++; $display("FAIL word32_timeout got 0 pops want 1"); end
    else begin
      checks++; if (q_instr[0] !== 32'h0000_0013 || q_pc[0] !== 32'h0 || q_comp[0] !== 1'b0)
        begin errors++; $display("FAIL word32 got %h@%h c%b want 00000013@0 c0", q_instr[0], q_pc[0], q_comp[0]); end
    end
    checks++; if (a1 !== 32'h4) begin errors++; $display("FAIL word32_next_addr got %h want 4", a1); end
    $display("test_word32 pops=%0d", q_instr.size());
  endtask

  task automatic test_compressed();
    prog[0] = 32'h4505_4501; prog[1] = 32'h4511_4509;
    do_reset();
    out_ready = 1'b1;
    collect(2, 30);
    checks++; if (q_instr.size() < 2) begin errors++; $display("FAIL comp_timeout got %0d pops want 2", q_instr.size()); end
    else begin
      checks++; if (q_instr[0] !== 32'h4501 || q_pc[0] !== 32'h0 || q_comp[0] !== 1'b1)
        begin errors++; $display("FAIL comp_first got %h@%h c%b want 00004501@0 c1", q_instr[0], q_pc[0], q_comp[0]); end
      checks++; if (q_instr[1] !== 32'h4505 || q_pc[1] !== 32'h2 || q_comp[1] !== 1'b1)
        begin errors++; $display("FAIL comp_second got %h@%h c%b want 00004505@2 c1", q_instr[1], q_pc[1], q_comp[1]); end
    end
    $display("test_compressed pops=%0d", q_instr.size());
  endtask

  task automatic test_split();
    bit w1_seen = 0, bad = 0;
    int w1_cyc = -1, pop1_cyc = -1;
    prog[0] = 32'h0513_4501; prog[1] = 32'h0000_0010;
    lat_min = 3; lat_max = 3;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && q_instr.size() < 2; i++) begin
      step();
      if (q_instr.size() == 1 && !w1_seen && obs_valid) bad = 1;
      if (obs_rvalid && obs_raddr == 32'h4 && !w1_seen) begin w1_seen = 1; w1_cyc = cyc; end
      if (obs_pop) begin
        q_instr.push_back(obs_instr); q_pc.push_back(obs_pc); q_comp.push_back(obs_comp);
        if (q_instr.size() == 2) pop1_cyc = cyc;
      end
    end
    checks++; if (q_instr.size() < 2) begin errors++; $display("FAIL split_timeout got %0d pops want 2", q_instr.size()); end
    else begin
      checks++; if (q_instr[0] !== 32'h4501 || q_pc[0] !== 32'h0)
        begin errors++; $display("FAIL split_cli got %h@%h want 00004501@0", q_instr[0], q_pc[0]); end
      checks++; if (q_instr[1] !== 32'h0010_0513 || q_pc[1] !== 32'h2 || q_comp[1] !== 1'b0)
        begin errors++; $display("FAIL split_instr got %h@%h c%b want 00100513@2 c0", q_instr[1], q_pc[1], q_comp[1]); end
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL split_gap_valid got 1 want 0"); end
    checks++; if (!(w1_seen && pop1_cyc > w1_cyc)) begin errors++; $display("FAIL split_order got pop@%0d word1@%0d want pop after word1", pop1_cyc, w1_cyc); end
    $display("test_split pops=%0d word1_cycle=%0d", q_instr.size(), w1_cyc);
  endtask

  task automatic test_redirect();
    logic [31:0] a0;
    prog[0] = 32'h0000_0013; prog[65] = 32'h4589_0001; prog[66] = 32'h0001_0001;
    lat_min = 3; lat_max = 3;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && gnt_log.size() < 1; i++) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0106;
    step();
    redirect = 1'b0;
    gnt_log.delete();
    collect(1, 40);
    a0 = (gnt_log.size() >= 1) ? gnt_log[0] : 32'hxxxx_xxxx;
    checks++; if (a0 !== 32'h104) begin errors++; $display("FAIL redirect_addr got %h want 00000104", a0); end
    checks++; if (q_instr.size() < 1) begin errors++; $display("FAIL redirect_timeout got 0 pops want 1"); end
    else begin
      checks++; if (q_instr[0] !== 32'h4589 || q_pc[0] !== 32'h106 || q_comp[0] !== 1'b1)
        begin errors++; $display("FAIL redirect_instr got %h@%h c%b want 00004589@106 c1", q_instr[0], q_pc[0], q_comp[0]); end
    end
    $display("test_redirect pops=%0d", q_instr.size());
  endtask

  task automatic test_backpressure();
    logic [31:0] snap_i, snap_p, pc;
    bit req_seen = 0, moved = 0;
    prog[0] = 32'h4505_4501; prog[1] = 32'h4511_4509; prog[2] = 32'h0000_0013; prog[3] = 32'h0000_0013;
    lat_min = 0; lat_max = 0;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h2;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) step();
    #1;
    snap_i = out_instr; snap_p = out_pc;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_req) req_seen = 1;
      if (obs_instr !== snap_i || obs_pc !== snap_p) moved = 1;
    end
    checks++; if (snap_i !== 32'h4505 || snap_p !== 32'h2) begin errors++; $display("FAIL bp_head got %h@%h want 00004505@2", snap_i, snap_p); end
    checks++; if (req_seen) begin errors++; $display("FAIL bp_req got 1 want 0 while full"); end
    checks++; if (moved) begin errors++; $display("FAIL bp_stable got change want stable"); end
    out_ready = 1'b1;
    collect(4, 40);
    checks++; if (q_instr.size() < 4) begin errors++; $display("FAIL bp_timeout got %0d pops want 4", q_instr.size()); end
    pc = 32'h2;
    for (int i = 0; i < q_instr.size(); i++) begin
      checks++;
      if (q_instr[i] !== ref_instr(pc) || q_pc[i] !== pc)
        begin errors++; $display("FAIL bp_drain%0d got %h@%h want %h@%h", i, q_instr[i], q_pc[i], ref_instr(pc), pc); end
      pc = pc + ((ref_instr(pc) >> 16) == 0 && hw_at(pc) != 16'h0 && hw_at(pc)[1:0] != 2'b11 ? 32'd2 : 32'd4);
    end
    $display("test_backpressure pops=%0d", q_instr.size());
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] pc;
    logic [15:0] lo;
    prog[0] = 32'h4505_4501; prog[1] = 32'h4511_4509; prog[2] = 32'h4519_4515;
    lat_min = 4; lat_max = 4;
    do_reset();
    for (int i = 0; i < 10 && gnt_log.size() < 1; i++) step();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (fetch_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midwait_outputs got req%b val%b want 0/0", fetch_req, out_valid); end
    checks++; if (fetch_addr !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL midwait_state got addr %h pc %h want 0/0", fetch_addr, out_pc); end
    @(negedge clk);
    step();
    rst = 1'b1;
    lat_min = 0; lat_max = 0;
    out_ready = 1'b1;
    q_instr.delete(); q_pc.delete(); q_comp.delete();
    collect(4, 60);
    checks++; if (q_instr.size() < 4) begin errors++; $display("FAIL midwait_timeout got %0d pops want 4", q_instr.size()); end
    pc = 32'h0;
    for (int i = 0; i < q_instr.size(); i++) begin
      lo = hw_at(pc);
      checks++;
      if (q_instr[i] !== ref_instr(pc) || q_pc[i] !== pc)
        begin errors++; $display("FAIL midwait_seq%0d got %h@%h want %h@%h", i, q_instr[i], q_pc[i], ref_instr(pc), pc); end
      pc = pc + ((lo[1:0] != 2'b11) ? 32'd2 : 32'd4);
    end
    $display("test_reset_mid_wait pops=%0d", q_instr.size());
  endtask

  task automatic test_wrap();
    logic [31:0] a0, a1;
    prog[255] = 32'h0513_0001; prog[0] = 32'h4501_0010; prog[1] = 32'h0000_0013;
    lat_min = 0; lat_max = 0;
    do_reset();
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    gnt_log.delete();
    collect(2, 40);
    a0 = (gnt_log.size() >= 1) ? gnt_log[0] : 32'hxxxx_xxxx;
    a1 = (gnt_log.size() >= 2) ? gnt_log[1] : 32'hxxxx_xxxx;
    checks++; if (a0 !== 32'hFFFF_FFFC || a1 !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h,%h want fffffffc,00000000", a0, a1); end
    checks++; if (q_instr.size() < 2) begin errors++; $display("FAIL wrap_timeout got %0d pops want 2", q_instr.size()); end
    else begin
      checks++; if (q_instr[0] !== 32'h0010_0513 || q_pc[0] !== 32'hFFFF_FFFE)
        begin errors++; $display("FAIL wrap_instr got %h@%h want 00100513@fffffffe", q_instr[0], q_pc[0]); end
      checks++; if (q_instr[1] !== 32'h4501 || q_pc[1] !== 32'h2)
        begin errors++; $display("FAIL wrap_next got %h@%h want 00004501@2", q_instr[1], q_pc[1]); end
    end
    $display("test_wrap pops=%0d", q_instr.size());
  endtask

  task automatic test_random();
    logic [31:0] model_pc, exp_i, rpc;
    logic [15:0] lo;
    bit          redir;
    int          pops = 0;
    for (int i = 0; i < 256; i++) prog[i] = $urandom;
    gnt_pct = 70; lat_min = 0; lat_max = 3;
    do_reset();
    model_pc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      out_ready   = ($urandom_range(0, 99) < 70);
      redir       = ($urandom_range(0, 99) < 3);
      rpc         = $urandom;
      redirect    = redir;
      redirect_pc = rpc;
      step();
      redirect = 1'b0;
      if (obs_pop) begin
        pops++;
        lo    = hw_at(model_pc);
        exp_i = ref_instr(model_pc);
        checks++;
        if (obs_instr !== exp_i || obs_pc !== model_pc || obs_comp !== (lo[1:0] != 2'b11)) begin
          errors++;
          if (errors < 20) $display("FAIL random_pop%0d got %h@%h c%b want %h@%h c%b", pops, obs_instr, obs_pc, obs_comp, exp_i, model_pc, lo[1:0] != 2'b11);
        end
        model_pc = model_pc + ((lo[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
      if (redir) model_pc = rpc & ~32'h1;
    end
    checks++; if (pops < 300) begin errors++; $display("FAIL random_throughput got %0d pops want >=300", pops); end
    $display("test_random pops=%0d", pops);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 32'h0000_0013;
    @(negedge clk);
    test_reset();
    test_word32();
    test_compressed();
    test_split();
    test_redirect();
    test_backpressure();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
